// File: rtl/network_pkg.sv
// network_pkg: shared sequencer state encoding and index-width helper.
package network_pkg;
    typedef enum logic [2:0] {IDLE, LSB, RST_CONV, RUN, ACC, OUTPUT, ABORT} seq_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-layer wait counter; flags expiry once TIMEOUT cycles have elapsed since clear.
module seq_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: per-tick forward-pass scheduler for the cached dilated conv network.
module layer_sequencer import network_pkg::*; #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1024,
    parameter int OVR_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic                          clr_err,
    input  logic [NUM_LAYERS-1:0]         conv_out_v,
    output logic                          lsb_clk,
    output logic [NUM_LAYERS-1:0]         conv_rst,
    output logic [NUM_LAYERS-2:0]         ac_clk,
    output logic                          out_latch,
    output logic                          busy,
    output logic [idx_w(NUM_LAYERS)-1:0]  cur_layer,
    output logic                          timeout_pulse,
    output logic                          timeout_err,
    output logic [OVR_W-1:0]              overrun_cnt
);
    localparam int LW = idx_w(NUM_LAYERS);

    seq_state_t r_state, w_next;
    logic [LW-1:0] r_layer, w_layer_next;
    logic r_pending, w_pending_next, w_ovr_inc, w_expired;

    // The watchdog counts from the RST_CONV cycle, so the abort lands TIMEOUT cycles after conv_rst.
    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_next == RST_CONV),
        .i_en     (r_state == RST_CONV || r_state == RUN),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next         = r_state;
        w_layer_next   = r_layer;
        w_pending_next = r_pending;
        w_ovr_inc      = 1'b0;
        case (r_state)
            IDLE:     w_next = sample_tick ? LSB : IDLE;
            LSB:      w_next = RST_CONV;
            RST_CONV: w_next = RUN;
            RUN:      w_next = conv_out_v[r_layer] ? ((r_layer == LW'(NUM_LAYERS - 1)) ? OUTPUT : ACC)
                                                   : (w_expired ? ABORT : RUN);
            ACC: begin
                w_next       = RST_CONV;
                w_layer_next = r_layer + 1'b1;
            end
            OUTPUT, ABORT: begin
                w_next         = (r_pending || sample_tick) ? LSB : IDLE;
                w_layer_next   = '0;
                w_pending_next = 1'b0;
            end
            default:  w_next = IDLE;
        endcase
        // A terminal-state tick starts the next pass directly; elsewhere it queues once, then overruns.
        if (sample_tick && !(r_state inside {IDLE, OUTPUT, ABORT})) begin
            w_pending_next = 1'b1;
            w_ovr_inc      = r_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_layer       <= '0;
            r_pending     <= 1'b0;
            lsb_clk       <= 1'b0;
            conv_rst      <= '0;
            ac_clk        <= '0;
            out_latch     <= 1'b0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_cnt   <= '0;
        end else begin
            r_state       <= w_next;
            r_layer       <= w_layer_next;
            r_pending     <= w_pending_next;
            lsb_clk       <= (w_next == LSB);
            conv_rst      <= (w_next == RST_CONV) ? NUM_LAYERS'(1) << w_layer_next : '0;
            ac_clk        <= (w_next == ACC) ? (NUM_LAYERS - 1)'(1) << r_layer : '0;
            out_latch     <= (w_next == OUTPUT);
            busy          <= !(w_next inside {IDLE, ABORT});
            timeout_pulse <= (w_next == ABORT);
            timeout_err   <= (w_next == ABORT) || (timeout_err && !clr_err);
            overrun_cnt   <= w_ovr_inc ? ((&overrun_cnt) ? overrun_cnt : overrun_cnt + 1'b1)
                                       : (clr_err ? '0 : overrun_cnt);
        end
    end

    assign cur_layer = r_layer;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed tables plus randomized passes checked against an interval-schedule model.
module tb_layer_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: two layers, short watchdog, 2-bit overrun counter.
    logic       a_rst = 1'b1, a_tick = 1'b0, a_clr = 1'b0, a_hang = 1'b0;
    logic [1:0] a_ov, a_crst, a_ovr;
    logic [0:0] a_ac, a_cur;
    logic       a_lsb, a_ol, a_busy, a_to, a_err;

    layer_sequencer #(.NUM_LAYERS(2), .TIMEOUT(16), .OVR_W(2)) u_a (
        .clk(clk), .rst(a_rst), .sample_tick(a_tick), .clr_err(a_clr), .conv_out_v(a_ov),
        .lsb_clk(a_lsb), .conv_rst(a_crst), .ac_clk(a_ac), .out_latch(a_ol), .busy(a_busy),
        .cur_layer(a_cur), .timeout_pulse(a_to), .timeout_err(a_err), .overrun_cnt(a_ovr)
    );

    // Instance B: four layers, default watchdog and counter width.
    logic       b_rst = 1'b1, b_tick = 1'b0, b_clr = 1'b0, b_force = 1'b0;
    logic [3:0] b_ov, b_crst;
    logic [2:0] b_ac;
    logic [1:0] b_cur;
    logic [7:0] b_ovr;
    logic       b_lsb, b_ol, b_busy, b_to, b_err;

    layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT(1024), .OVR_W(8)) u_b (
        .clk(clk), .rst(b_rst), .sample_tick(b_tick), .clr_err(b_clr), .conv_out_v(b_ov),
        .lsb_clk(b_lsb), .conv_rst(b_crst), .ac_clk(b_ac), .out_latch(b_ol), .busy(b_busy),
        .cur_layer(b_cur), .timeout_pulse(b_to), .timeout_err(b_err), .overrun_cnt(b_ovr)
    );

    // Conv layer models: out_v rises a fixed (A) or table-given (B) number of cycles after conv_rst.
    int a_cnt [2] = '{0, 0};
    int b_cnt [4] = '{0, 0, 0, 0};
    int b_lc  [4] = '{1, 1, 1, 1};
    int b_k   [4] = '{0, 0, 0, 0};
    int lat [256][4];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            a_cnt[i] <= a_crst[i] ? 1 : (a_cnt[i] < 1000 ? a_cnt[i] + 1 : a_cnt[i]);
        for (int i = 0; i < 4; i++) begin
            if (b_crst[i]) begin
                b_cnt[i] <= 1;
                b_lc[i]  <= lat[b_k[i] % 256][i];
                b_k[i]   <= b_k[i] + 1;
            end else if (b_cnt[i] < 1000) begin
                b_cnt[i] <= b_cnt[i] + 1;
            end
        end
    end

    assign a_ov[0] = (a_cnt[0] >= 5);
    assign a_ov[1] = (a_cnt[1] >= 5) && !a_hang;
    always_comb
        for (int i = 0; i < 4; i++)
            b_ov[i] = b_force || (b_cnt[i] >= b_lc[i]);

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int g[$], input int e[$]);
        chk({nm, "_count"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), g[i], e[i]);
    endtask

    bit tk [512];

    task automatic set_tk(input int t[$]);
        foreach (tk[i]) tk[i] = 1'b0;
        foreach (t[i]) tk[t[i]] = 1'b1;
    endtask

    int qa_lsb[$], qa_c0[$], qa_c1[$], qa_ac[$], qa_ol[$], qa_to[$];

    task automatic run_a(input int n, input int rst_at);
        qa_lsb = {}; qa_c0 = {}; qa_c1 = {}; qa_ac = {}; qa_ol = {}; qa_to = {};
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (a_lsb)    qa_lsb.push_back(c);
            if (a_crst[0]) qa_c0.push_back(c);
            if (a_crst[1]) qa_c1.push_back(c);
            if (a_ac[0])  qa_ac.push_back(c);
            if (a_ol)     qa_ol.push_back(c);
            if (a_to)     qa_to.push_back(c);
            if (rst_at >= 0 && c == rst_at + 1)
                chk("rst_midpass_outputs",
                    {a_lsb, a_crst, a_ac, a_ol, a_busy, a_cur, a_to, a_err, a_ovr}, 0);
            a_rst  = (c == rst_at);
            a_tick = tk[c];
        end
        a_rst  = 1'b0;
        a_tick = 1'b0;
    endtask

    int qb_lsb[$], qb_ol[$];
    int qb_crst [4][$];
    int qb_ac [3][$];
    bit exp_busy [512];

    task automatic run_b(input int n, input bit check_busy);
        qb_lsb = {}; qb_ol = {};
        for (int i = 0; i < 4; i++) qb_crst[i] = {};
        for (int i = 0; i < 3; i++) qb_ac[i] = {};
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (b_lsb) qb_lsb.push_back(c);
            if (b_ol)  qb_ol.push_back(c);
            for (int i = 0; i < 4; i++) if (b_crst[i]) qb_crst[i].push_back(c);
            for (int i = 0; i < 3; i++) if (b_ac[i]) qb_ac[i].push_back(c);
            if (check_busy) chk($sformatf("rand_busy_c%0d", c), b_busy, exp_busy[c]);
            b_tick = tk[c];
        end
        b_tick = 1'b0;
    endtask

    // Reference model: each pass is a fixed interval computed from per-layer latencies;
    // ticks are classified by where they fall relative to the active interval.
    int e_lsb[$], e_ol[$];
    int e_crst [4][$];
    int e_ac [3][$];
    int m_pass, m_end, m_base;

    task automatic sched(input int s);
        int c, seen;
        e_lsb.push_back(s);
        c = s + 1;
        for (int i = 0; i < 4; i++) begin
            e_crst[i].push_back(c);
            seen = c + lat[m_base + m_pass][i];
            if (i < 3) begin
                e_ac[i].push_back(seen + 1);
                c = seen + 2;
            end else begin
                m_end = seen + 1;
            end
        end
        e_ol.push_back(m_end);
        for (int t = s; t <= m_end && t < 512; t++) exp_busy[t] = 1'b1;
        m_pass++;
    endtask

    typedef struct {
        logic       tick;
        logic [6:0] exp;
    } vec_t;
    vec_t vt [18];

    initial begin
        int act, pend, ovr;
        for (int p = 0; p < 256; p++)
            for (int i = 0; i < 4; i++) lat[p][i] = 1;
        for (int c = 0; c < 18; c++) begin
            vt[c].tick = (c == 0);
            vt[c].exp  = {c == 1, c == 9, c == 2, c == 8, c == 15, c >= 1 && c <= 15, c >= 9 && c <= 15};
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {a_lsb, a_crst, a_ac, a_ol, a_busy, a_cur, a_to, a_err, a_ovr}, 0);
        chk("reset_b", {b_lsb, b_crst, b_ac, b_ol, b_busy, b_cur, b_to, b_err, b_ovr}, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Single pass, cycle by cycle: {lsb, crst[1:0], ac, latch, busy, cur_layer}.
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            chk($sformatf("pass_c%0d", c), {a_lsb, a_crst, a_ac, a_ol, a_busy, a_cur}, vt[c].exp);
            a_tick = vt[c].tick;
        end
        a_tick = 1'b0;

        // One early tick is queued and starts right after out_latch.
        set_tk('{0, 6});
        run_a(34, -1);
        chk_q("queued_lsb", qa_lsb, '{1, 16});
        chk_q("queued_latch", qa_ol, '{15, 30});
        chk("queued_no_overrun", a_ovr, 0);

        // Extra ticks overrun, then saturate the 2-bit counter.
        set_tk('{0, 4, 5, 6});
        run_a(34, -1);
        chk_q("ovr_lsb", qa_lsb, '{1, 16});
        chk("ovr_count2", a_ovr, 2);
        set_tk('{0, 2, 3, 4, 5, 6, 7});
        run_a(34, -1);
        chk("ovr_saturate", a_ovr, 3);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("ovr_cleared", a_ovr, 0);

        // Hung last layer: watchdog aborts 16 cycles after its conv_rst.
        a_hang = 1'b1;
        set_tk('{0});
        run_a(30, -1);
        a_hang = 1'b0;
        chk_q("hang_crst1", qa_c1, '{9});
        chk_q("hang_timeout", qa_to, '{25});
        chk("hang_no_latch", qa_ol.size(), 0);
        chk("hang_err_sticky", a_err, 1);
        chk("hang_idle", {a_busy, a_cur}, 0);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("hang_err_cleared", a_err, 0);

        // Reset the cycle after conv_rst[1], then restart cleanly.
        set_tk('{0, 14});
        run_a(32, 10);
        chk_q("rst_lsb", qa_lsb, '{1, 15});
        chk_q("rst_crst0", qa_c0, '{2, 16});
        chk_q("rst_crst1", qa_c1, '{9, 23});
        chk_q("rst_ac", qa_ac, '{8, 22});
        chk_q("rst_latch", qa_ol, '{29});

        // Four layers with out_v held high: conv_rst every 3 cycles.
        b_force = 1'b1;
        set_tk('{0, 20});
        run_b(40, 1'b0);
        b_force = 1'b0;
        for (int i = 0; i < 4; i++)
            chk_q($sformatf("fast_crst%0d", i), qb_crst[i], '{2 + 3 * i, 22 + 3 * i});
        for (int i = 0; i < 3; i++)
            chk_q($sformatf("fast_ac%0d", i), qb_ac[i], '{4 + 3 * i, 24 + 3 * i});
        chk_q("fast_latch", qb_ol, '{13, 33});

        // Randomized ticks and latencies against the interval model.
        m_base = b_k[0];
        m_pass = 0;
        for (int p = m_base; p < 256; p++)
            for (int i = 0; i < 4; i++) lat[p][i] = int'($urandom_range(6, 1));
        foreach (tk[i]) tk[i] = (i < 420) && ($urandom_range(11) == 0);
        foreach (exp_busy[i]) exp_busy[i] = 1'b0;
        e_lsb = {}; e_ol = {};
        for (int i = 0; i < 4; i++) e_crst[i] = {};
        for (int i = 0; i < 3; i++) e_ac[i] = {};
        act = 0; pend = 0; ovr = 0;
        for (int t = 0; t < 512; t++) begin
            if (act == 0) begin
                if (tk[t]) begin
                    sched(t + 1);
                    act = 1;
                end
            end else if (t == m_end) begin
                if (pend != 0 || tk[t]) begin
                    sched(t + 1);
                    pend = 0;
                end else begin
                    act = 0;
                end
            end else if (tk[t]) begin
                if (pend != 0) ovr++;
                else pend = 1;
            end
        end
        run_b(512, 1'b1);
        chk_q("rand_lsb", qb_lsb, e_lsb);
        chk_q("rand_latch", qb_ol, e_ol);
        for (int i = 0; i < 4; i++) chk_q($sformatf("rand_crst%0d", i), qb_crst[i], e_crst[i]);
        for (int i = 0; i < 3; i++) chk_q($sformatf("rand_ac%0d", i), qb_ac[i], e_ac[i]);
        chk("rand_overrun", b_ovr, ovr);
        chk("rand_no_timeout", b_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
